mod_exp_engine: RTL and testbench



---
 rtl/mod_exp_pkg.sv | 23 ++
 rtl/mod_exp_engine_mod_mult.sv | 47 ++++
 rtl/mod_exp_engine.sv | 180 ++++++++++++++++++
 tb/tb_mod_exp_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_exp_pkg.sv
// Shared types and width helpers for the modular exponentiation engine.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REDUCE,
    SCAN,
    SQUARE,
    MULT,
    DONE
  } state_t;

  function automatic int bytes_to_bits(input int n_bytes);
    return 8 * n_bytes;
  endfunction

  // Width of a bit index into a vector of the given width.
  function automatic int index_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mod_exp_engine_mod_mult.sv
// Two-stage modular multiplier: full-width product, then reduction mod m.
// One op per ready_in pulse; valid_out pulses once with the reduced result.
module mod_mult
  import mod_exp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] value_out,
  output logic             busy_out,
  output logic             valid_out
);

  localparam int PROD_WIDTH = 2 * WIDTH;

  logic [PROD_WIDTH-1:0] product_q;
  logic [WIDTH-1:0]      modulus_q;

  // Multiply stage on accept, reduce stage on the following cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      product_q <= '0;
      modulus_q <= '0;
      value_out <= '0;
      busy_out  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      // NOTE: every sequential assignment is non-blocking so all registers see pre-edge values.
      valid_out <= 1'b0;
      if (ready_in && !busy_out) begin
        product_q <= PROD_WIDTH'(a_in) * PROD_WIDTH'(b_in);
        modulus_q <= modulus_in;
        busy_out  <= 1'b1;
      end else if (busy_out) begin
        value_out <= WIDTH'(product_q % PROD_WIDTH'(modulus_q));
        valid_out <= 1'b1;
        busy_out  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mod_exp_engine.sv
// Left-to-right square-and-multiply engine: value^exponent mod modulus.
// Operands are latched at start; degenerate operands resolve in CHECK.
// MSG_WIDTH must not exceed KEY_WIDTH (base is zero-extended).
module mod_exp_engine
  import mod_exp_pkg::*;
#(
  parameter int MSG_BYTES = 2,
  parameter int KEY_BYTES = 4,
  parameter int EXP_BYTES = KEY_BYTES,
  localparam int MSG_WIDTH = bytes_to_bits(MSG_BYTES),
  localparam int KEY_WIDTH = bytes_to_bits(KEY_BYTES),
  localparam int EXP_WIDTH = bytes_to_bits(EXP_BYTES),
  localparam int IDX_WIDTH = index_width(EXP_WIDTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 ready_in,
  input  logic [MSG_WIDTH-1:0] value_in,
  input  logic [KEY_WIDTH-1:0] modulus_in,
  input  logic [EXP_WIDTH-1:0] exponent_in,
  output logic [KEY_WIDTH-1:0] value_out,
  output logic                 busy_out,
  output logic                 valid_out,
  output logic                 err_out
);

  state_t               state;
  logic [MSG_WIDTH-1:0] base_q;
  logic [KEY_WIDTH-1:0] m_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [KEY_WIDTH-1:0] acc_q;
  logic [KEY_WIDTH-1:0] b_q;
  logic [IDX_WIDTH-1:0] idx_q;
  logic                 err_q;
  logic                 pending_q;  // a mod_mult op is in flight for this state

  logic                 mm_ready;
  logic [KEY_WIDTH-1:0] mm_a;
  logic [KEY_WIDTH-1:0] mm_b;
  logic [KEY_WIDTH-1:0] mm_result;
  logic                 mm_busy;
  logic                 mm_valid;

  mod_mult #(.WIDTH(KEY_WIDTH)) u_mult (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .ready_in   (mm_ready),
    .a_in       (mm_a),
    .b_in       (mm_b),
    .modulus_in (m_q),
    .value_out  (mm_result),
    .busy_out   (mm_busy),
    .valid_out  (mm_valid)
  );

  // Control FSM plus datapath registers; all outputs are registered.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: datapath registers are cleared with the FSM so a mid-operation reset leaves no stale operand.
      state     <= IDLE;
      base_q    <= '0;
      m_q       <= '0;
      e_q       <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
      mm_ready  <= 1'b0;
      mm_a      <= '0;
      mm_b      <= '0;
      value_out <= '0;
      busy_out  <= 1'b0;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      mm_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (ready_in && !busy_out) begin
            base_q   <= value_in;
            m_q      <= modulus_in;
            e_q      <= exponent_in;
            busy_out <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          err_q     <= 1'b0;
          pending_q <= 1'b0;
          idx_q     <= IDX_WIDTH'(EXP_WIDTH - 1);
          if (m_q == '0) begin
            acc_q <= '0;
            err_q <= 1'b1;
            state <= DONE;
          end else if (m_q == KEY_WIDTH'(1)) begin
            acc_q <= '0;
            state <= DONE;
          end else if (e_q == '0) begin
            acc_q <= KEY_WIDTH'(1);
            state <= DONE;
          end else begin
            state <= REDUCE;
          end
        end
        REDUCE: begin
          if (!pending_q && !mm_busy) begin
            mm_a      <= KEY_WIDTH'(base_q);
            mm_b      <= KEY_WIDTH'(1);
            mm_ready  <= 1'b1;
            pending_q <= 1'b1;
          end else if (mm_valid) begin
            b_q       <= mm_result;
            acc_q     <= mm_result;
            pending_q <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          // The leading one is consumed by acc = b.
          if (e_q[idx_q]) begin
            if (idx_q == '0) begin
              state <= DONE;
            end else begin
              idx_q <= idx_q - IDX_WIDTH'(1);
              state <= SQUARE;
            end
          end else begin
            idx_q <= idx_q - IDX_WIDTH'(1);
          end
        end
        SQUARE: begin
          if (!pending_q && !mm_busy) begin
            mm_a      <= acc_q;
            mm_b      <= acc_q;
            mm_ready  <= 1'b1;
            pending_q <= 1'b1;
          end else if (mm_valid) begin
            acc_q     <= mm_result;
            pending_q <= 1'b0;
            if (e_q[idx_q]) begin
              state <= MULT;
            end else if (idx_q == '0) begin
              state <= DONE;
            end else begin
              idx_q <= idx_q - IDX_WIDTH'(1);
            end
          end
        end
        MULT: begin
          if (!pending_q && !mm_busy) begin
            mm_a      <= acc_q;
            mm_b      <= b_q;
            mm_ready  <= 1'b1;
            pending_q <= 1'b1;
          end else if (mm_valid) begin
            acc_q     <= mm_result;
            pending_q <= 1'b0;
            if (idx_q == '0) begin
              state <= DONE;
            end else begin
              idx_q <= idx_q - IDX_WIDTH'(1);
              state <= SQUARE;
            end
          end
        end
        DONE: begin
          value_out <= acc_q;
          err_out   <= err_q;
          valid_out <= 1'b1;
          busy_out  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Scoreboard bench for mod_exp_engine (MSG 16b, KEY 32b, EXP 64b).
`timescale 1ns/1ps
module tb_mod_exp_engine;
  import mod_exp_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        ready_in;
  logic [15:0] value_in;
  logic [31:0] modulus_in;
  logic [63:0] exponent_in;
  logic [31:0] value_out;
  logic        busy_out;
  logic        valid_out;
  logic        err_out;

  mod_exp_engine #(.MSG_BYTES(2), .KEY_BYTES(4), .EXP_BYTES(8)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .ready_in    (ready_in),
    .value_in    (value_in),
    .modulus_in  (modulus_in),
    .exponent_in (exponent_in),
    .value_out   (value_out),
    .busy_out    (busy_out),
    .valid_out   (valid_out),
    .err_out     (err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] value;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   ops_count = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Right-to-left reference: independent of the engine's scan order.
  function automatic logic [31:0] model(input logic [15:0] v, input logic [31:0] m, input logic [63:0] e);
    longint unsigned r, b, mm;
    logic [63:0] ee;
    if (m <= 32'd1) return 32'd0;
    mm = longint'(m);
    r  = 1;
    b  = longint'(v) % mm;
    ee = e;
    while (ee != 0) begin
      if (ee[0]) r = (r * b) % mm;
      b  = (b * b) % mm;
      ee = ee >> 1;
    end
    return r[31:0];
  endfunction

  // Count mod_mult operations issued by the engine.
  always @(posedge clk_in) if (dut.mm_ready) ops_count++;

  // Monitor: every valid_out pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (valid_out) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got value %0d with no expected result queued", value_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_value", value_out, e.value);
        check("result_err", err_out, e.err);
      end
    end
  end

  // Starts an op from the current time; returns at posedge+1 with valid_out seen.
  task automatic run_op(input logic [15:0] v, input logic [31:0] m, input logic [63:0] e,
                        input logic [31:0] exp_val, input logic exp_err, input bit churn,
                        output int cycles);
    exp_t x;
    bit   seen;
    seen        = 0;
    cycles      = 0;
    value_in    = v;
    modulus_in  = m;
    exponent_in = e;
    ready_in    = 1'b1;
    x.value     = exp_val;
    x.err       = exp_err;
    sb_q.push_back(x);
    for (int k = 1; k <= 2000; k++) begin
      @(posedge clk_in);
      #1;
      if (k == 1) check("busy_after_accept", busy_out, 1);
      if (valid_out) begin
        check("busy_low_with_valid", busy_out, 0);
        cycles = k;
        seen   = 1;
        break;
      end
      if (churn) begin
        value_in    = 16'($urandom);
        modulus_in  = $urandom;
        exponent_in = {$urandom, $urandom};
        ready_in    = (k == 5);
      end else begin
        ready_in = 1'b0;
      end
    end
    ready_in = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL op_timeout: got no valid_out within 2000 cycles, required one");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc;
    logic [15:0] rv;
    logic [31:0] rm;
    logic [63:0] re;

    rst_in      = 1'b1;
    ready_in    = 1'b0;
    value_in    = '0;
    modulus_in  = '0;
    exponent_in = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_value", value_out, 0);
    check("reset_busy", busy_out, 0);
    check("reset_valid", valid_out, 0);
    check("reset_err", err_out, 0);
    rst_in = 1'b0;

    // Main function and op counts.
    @(negedge clk_in);
    ops_count = 0;
    run_op(16'd4, 32'd497, 64'd13, 32'd445, 1'b0, 0, cyc);
    check("ops_4_13_497", ops_count, 6);

    @(negedge clk_in);
    run_op(16'd100, 32'd7, 64'd3, 32'd1, 1'b0, 0, cyc);

    @(negedge clk_in);
    ops_count = 0;
    run_op(16'd12, 32'd5, 64'd1, 32'd2, 1'b0, 0, cyc);
    check("ops_exp1", ops_count, 1);

    // Degenerate operands: fixed three-cycle latency.
    @(negedge clk_in);
    run_op(16'd5, 32'd13, 64'd0, 32'd1, 1'b0, 0, cyc);
    check("latency_exp0", cyc, 3);
    @(negedge clk_in);
    run_op(16'd9, 32'd1, 64'd7, 32'd0, 1'b0, 0, cyc);
    check("latency_m1", cyc, 3);
    @(negedge clk_in);
    run_op(16'd9, 32'd0, 64'd7, 32'd0, 1'b1, 0, cyc);
    check("latency_m0", cyc, 3);

    // Operand churn plus an ignored start while busy.
    @(negedge clk_in);
    run_op(16'd4, 32'd497, 64'd13, 32'd445, 1'b0, 1, cyc);
    repeat (20) @(negedge clk_in);
    check("no_second_result", busy_out, 0);

    // Reset during SQUARE on a long operation (no result expected).
    run_op(16'd100, 32'd7, 64'd3, 32'd1, 1'b0, 0, cyc);
    @(negedge clk_in);
    value_in    = 16'd3;
    modulus_in  = 32'd4294967291;
    exponent_in = 64'h8000_0000_0000_0001;
    ready_in    = 1'b1;
    @(negedge clk_in);
    ready_in = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int k = 0; k < 300; k++) begin
        if (dut.state == SQUARE) begin
          hit = 1;
          break;
        end
        @(negedge clk_in);
      end
      if (!hit) begin
        total++;
        bad++;
        $display("FAIL square_timeout: got state %0d, required SQUARE within 300 cycles", dut.state);
      end
    end
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("midreset_value", value_out, 0);
    check("midreset_busy", busy_out, 0);
    check("midreset_valid", valid_out, 0);
    check("midreset_err", err_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (10) @(negedge clk_in);

    // Recovery and back-to-back starts.
    run_op(16'd2, 32'd1000, 64'd10, 32'd24, 1'b0, 0, cyc);
    run_op(16'd100, 32'd7, 64'd3, 32'd1, 1'b0, 0, cyc);

    // Wide exponent against the reference model.
    @(negedge clk_in);
    ops_count = 0;
    run_op(16'd3, 32'd4294967291, 64'h8000_0000_0000_0001,
           model(16'd3, 32'd4294967291, 64'h8000_0000_0000_0001), 1'b0, 0, cyc);
    check("ops_wide", ops_count, 65);

    // Random sweep against the reference model.
    for (int n = 0; n < 40; n++) begin
      rv = 16'($urandom);
      rm = (n % 2 == 0) ? 32'($urandom_range(2, 50)) : $urandom;
      re = {$urandom, $urandom} >> $urandom_range(0, 63);
      @(negedge clk_in);
      run_op(rv, rm, re, model(rv, rm, re), (rm == 32'd0), 0, cyc);
    end

    repeat (5) @(negedge clk_in);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
